// File: rtl/axi_lite_reg_file_slave.sv
// AXI4-Lite slave with a bank of byte-strobed 32-bit registers, exposed to the fabric with per-register write pulses.
// Optional macro AXI_REG_FILE_SLVERR_EN: out-of-range indices return SLVERR instead of aliasing modulo NUM_REGS.
module axi_lite_reg_file_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REG_OUT,
    output logic [NUM_REGS-1:0]                REG_WR_PULSE
);

    localparam int DW         = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W     = DW / 8;
    localparam int FULL_IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                            r_rstDone;
    logic                            r_awHeld;
    logic                            r_wHeld;
    logic [FULL_IDX_W-1:0]           r_awIdx;
    logic [DW-1:0]                   r_wData;
    logic [STRB_W-1:0]               r_wStrb;
    logic [NUM_REGS-1:0][DW-1:0]     r_regs;
    logic [NUM_REGS-1:0]             r_wrPulse;
    logic                            r_bValid;
    logic [1:0]                      r_bResp;
    logic                            r_rValid;
    logic [1:0]                      r_rResp;
    logic [DW-1:0]                   r_rData;

    logic                            w_awReady;
    logic                            w_wReady;
    logic                            w_arReady;
    logic                            w_awHs;
    logic                            w_wHs;
    logic                            w_arHs;
    logic                            w_commit;
    logic [FULL_IDX_W-1:0]           w_rdIdx;
    logic [IDX_W-1:0]                w_wrSel;
    logic [IDX_W-1:0]                w_rdSel;
    logic                            w_wrOk;
    logic                            w_rdOk;
    logic                            w_unused;

    assign w_awReady = r_rstDone & ~r_awHeld & ~r_bValid;
    assign w_wReady  = r_rstDone & ~r_wHeld  & ~r_bValid;
    assign w_arReady = r_rstDone & ~r_rValid;
    assign w_awHs    = S_AXI_AWVALID & w_awReady;
    assign w_wHs     = S_AXI_WVALID  & w_wReady;
    assign w_arHs    = S_AXI_ARVALID & w_arReady;
    assign w_commit  = r_awHeld & r_wHeld & ~r_bValid;

    assign w_rdIdx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wrSel = r_awIdx[IDX_W-1:0];
    assign w_rdSel = w_rdIdx[IDX_W-1:0];

`ifdef AXI_REG_FILE_SLVERR_EN
    assign w_wrOk = ({{(32-FULL_IDX_W){1'b0}}, r_awIdx} < 32'(NUM_REGS));
    assign w_rdOk = ({{(32-FULL_IDX_W){1'b0}}, w_rdIdx} < 32'(NUM_REGS));
`else
    assign w_wrOk = 1'b1;
    assign w_rdOk = 1'b1;
`endif

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], r_awIdx, w_rdIdx};

    assign S_AXI_AWREADY = w_awReady;
    assign S_AXI_WREADY  = w_wReady;
    assign S_AXI_ARREADY = w_arReady;
    assign S_AXI_BVALID  = r_bValid;
    assign S_AXI_BRESP   = r_bResp;
    assign S_AXI_RVALID  = r_rValid;
    assign S_AXI_RRESP   = r_rResp;
    assign S_AXI_RDATA   = r_rData;
    assign REG_OUT       = r_regs;
    assign REG_WR_PULSE  = r_wrPulse;

    // Write side: independent AW/W holding latches, then one commit edge that raises B.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rstDone <= 1'b0;
            r_awHeld  <= 1'b0;
            r_wHeld   <= 1'b0;
            r_awIdx   <= '0;
            r_wData   <= '0;
            r_wStrb   <= '0;
            r_bValid  <= 1'b0;
            r_bResp   <= RESP_OKAY;
        end else begin
            r_rstDone <= 1'b1;
            if (w_awHs) begin
                r_awHeld <= 1'b1;
                r_awIdx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_wHs) begin
                r_wHeld <= 1'b1;
                r_wData <= S_AXI_WDATA;
                r_wStrb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_awHeld <= 1'b0;
                r_wHeld  <= 1'b0;
                r_bValid <= 1'b1;
                r_bResp  <= w_wrOk ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bValid && S_AXI_BREADY) begin
                r_bValid <= 1'b0;
                r_bResp  <= RESP_OKAY;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_regs    <= '0;
            r_wrPulse <= '0;
        end else begin
            r_wrPulse <= '0;
            if (w_commit && w_wrOk) begin
                r_wrPulse[w_wrSel] <= 1'b1;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (w_commit && w_wrOk && (w_wrSel == IDX_W'(i)) && r_wStrb[b]) begin
                        r_regs[i][8*b +: 8] <= r_wData[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read side samples the pre-edge register value, so a same-edge commit is not visible yet.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rValid <= 1'b0;
            r_rResp  <= RESP_OKAY;
            r_rData  <= '0;
        end else if (w_arHs) begin
            r_rValid <= 1'b1;
            r_rResp  <= w_rdOk ? RESP_OKAY : RESP_SLVERR;
            r_rData  <= w_rdOk ? r_regs[w_rdSel] : '0;
        end else if (r_rValid && S_AXI_RREADY) begin
            r_rValid <= 1'b0;
            r_rResp  <= RESP_OKAY;
            r_rData  <= '0;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_file_slave.sv
// Directed, table-driven bench for axi_lite_reg_file_slave; honours AXI_REG_FILE_SLVERR_EN when defined.
module tb_axi_lite_reg_file_slave;

    logic         ACLK;
    logic         ARESETN;
    logic [5:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [5:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] REG_OUT;
    logic [3:0]   REG_WR_PULSE;

    int errors = 0;
    int checks = 0;

    axi_lite_reg_file_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .NUM_REGS(4)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .REG_OUT(REG_OUT), .REG_WR_PULSE(REG_WR_PULSE)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Write with AW and W presented together; returns BRESP after the B handshake.
    task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [1:0] resp);
        int  cnt;
        logic awHs, wHs;
        @(negedge ACLK);
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        cnt = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && cnt < 50) begin
            awHs = S_AXI_AWVALID && S_AXI_AWREADY;
            wHs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (awHs) S_AXI_AWVALID = 1'b0;
            if (wHs)  S_AXI_WVALID  = 1'b0;
            @(negedge ACLK);
            cnt++;
        end
        while (!S_AXI_BVALID && cnt < 50) begin
            @(negedge ACLK);
            cnt++;
        end
        checkOutput("writeTimeout", {127'd0, cnt >= 50}, 128'd0);
        resp = S_AXI_BRESP;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic doRead(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int  cnt;
        logic arHs;
        @(negedge ACLK);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        cnt = 0;
        while (S_AXI_ARVALID && cnt < 50) begin
            arHs = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (arHs) S_AXI_ARVALID = 1'b0;
            @(negedge ACLK);
            cnt++;
        end
        while (!S_AXI_RVALID && cnt < 50) begin
            @(negedge ACLK);
            cnt++;
        end
        checkOutput("readTimeout", {127'd0, cnt >= 50}, 128'd0);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] rdata;

    initial begin
        vecs[0] = '{6'h00, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{6'h04, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{6'h08, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{6'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004};
        vecs[4] = '{6'h08, 32'h1111_1111, 4'hF, 32'h1111_1111};
        vecs[5] = '{6'h08, 32'hAABB_CCDD, 4'b0010, 32'h1111_CC11};
        vecs[6] = '{6'h0C, 32'hFFFF_FFFF, 4'b1001, 32'hFF00_00FF};
        vecs[7] = '{6'h04, 32'h1234_5678, 4'b0000, 32'h0000_0002};

        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

        repeat (20) @(negedge ACLK);
        checkOutput("rstReadys", {125'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 128'd0);
        checkOutput("rstValids", {126'd0, S_AXI_BVALID, S_AXI_RVALID}, 128'd0);
        checkOutput("rstRegOut", REG_OUT, 128'd0);
        ARESETN = 1'b1;
        checkOutput("readyBeforeRstDone", {127'd0, S_AXI_AWREADY}, 128'd0);
        @(negedge ACLK);
        checkOutput("readyAfterRstDone", {125'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 128'd7);

        // Write/readback table
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp);
            checkOutput($sformatf("vec%0d_bresp", i), {126'd0, resp}, 128'd0);
            doRead(vecs[i].addr, rdata, resp);
            checkOutput($sformatf("vec%0d_rdata", i), {96'd0, rdata}, {96'd0, vecs[i].expRead});
            checkOutput($sformatf("vec%0d_rresp", i), {126'd0, resp}, 128'd0);
            if (i == 3) begin
                checkOutput("regOutInit", REG_OUT, {32'd4, 32'd3, 32'd2, 32'd1});
            end
        end
        checkOutput("regOutTable", REG_OUT, {32'hFF00_00FF, 32'h1111_CC11, 32'd2, 32'd1});

        // W three cycles ahead of AW, then B stalled with a second write queued
        @(negedge ACLK);
        S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h0000_00A5; S_AXI_WSTRB = 4'hF;
        S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        checkOutput("wReadyIdle", {127'd0, S_AXI_WREADY}, 128'd1);
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        checkOutput("wReadyHeld", {127'd0, S_AXI_WREADY}, 128'd0);
        @(negedge ACLK);
        @(negedge ACLK);
        checkOutput("noEarlyCommit", {123'd0, S_AXI_BVALID, REG_WR_PULSE}, 128'd0);
        S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        @(negedge ACLK);
        checkOutput("bvalidAfterAwHs", {123'd0, S_AXI_BVALID, REG_WR_PULSE}, 128'd0);
        @(negedge ACLK);
        checkOutput("commitPulse", {123'd0, S_AXI_BVALID, REG_WR_PULSE}, {123'd0, 1'b1, 4'b0010});
        checkOutput("commitReg1", {96'd0, REG_OUT[63:32]}, 128'h0000_00A5);
        S_AXI_WDATA = 32'h0000_005A;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        @(negedge ACLK);
        checkOutput("pulseOneCycle", {124'd0, REG_WR_PULSE}, 128'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("bStall%0d", k),
                        {92'd0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY, REG_OUT[63:32]},
                        {92'd0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_00A5});
            @(negedge ACLK);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        checkOutput("readyAfterB", {125'd0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 128'd3);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        @(negedge ACLK);
        checkOutput("queuedNotYet", {95'd0, S_AXI_BVALID, REG_OUT[63:32]}, 128'h0000_00A5);
        @(negedge ACLK);
        checkOutput("queuedCommit", {91'd0, S_AXI_BVALID, REG_WR_PULSE, REG_OUT[63:32]},
                    {91'd0, 1'b1, 4'b0010, 32'h0000_005A});
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;

        // Out-of-range address 0x10
        applyStimulus(6'h10, 32'hDEAD_BEEF, 4'hF, resp);
        doRead(6'h10, rdata, resp);
`ifdef AXI_REG_FILE_SLVERR_EN
        checkOutput("oorRead", {94'd0, resp, rdata}, {94'd0, 2'b10, 32'd0});
        checkOutput("oorReg0", {96'd0, REG_OUT[31:0]}, 128'd1);
`else
        checkOutput("oorRead", {94'd0, resp, rdata}, {94'd0, 2'b00, 32'hDEAD_BEEF});
        checkOutput("oorReg0", {96'd0, REG_OUT[31:0]}, 128'hDEAD_BEEF);
`endif

        // AR on the commit edge of a write to the same register
        @(negedge ACLK);
        S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h0000_0055; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = 6'h04; S_AXI_RREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        checkOutput("collideRead", {94'd0, S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA},
                    {94'd0, 1'b1, 1'b1, 32'h0000_005A});
        checkOutput("collideReg", {96'd0, REG_OUT[63:32]}, 128'h0000_0055);
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        checkOutput("rdataClears", {95'd0, S_AXI_RVALID, S_AXI_RDATA}, 128'd0);
        doRead(6'h04, rdata, resp);
        checkOutput("readAfterCollide", {96'd0, rdata}, 128'h0000_0055);
        checkOutput("bStillPending", {127'd0, S_AXI_BVALID}, 128'd1);

        // Reset with B outstanding
        @(negedge ACLK);
        ARESETN = 1'b0;
        @(negedge ACLK);
        checkOutput("midRstCtrl",
                    {116'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                     S_AXI_BRESP, S_AXI_RVALID, S_AXI_RRESP, REG_WR_PULSE[2:0]}, 128'd0);
        checkOutput("midRstData", {92'd0, REG_WR_PULSE[3], S_AXI_RDATA}, 128'd0);
        checkOutput("midRstRegOut", REG_OUT, 128'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_file_slave.md
# axi_lite_reg_file_slave

AXI4-Lite responder that implements a small bank of 32-bit read/write registers with byte-lane strobes. It is the slave end of the control path driven by the AXI VIP master in the block-design wrapper. It also exposes every register and a per-register write pulse to the surrounding fabric. Write and read channels are independent and each allows one outstanding transaction.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width; register index = S_AXI_AWADDR/ARADDR[C_S_AXI_ADDR_WIDTH-1:2].
- NUM_REGS, 4, number of implemented registers; must be a power of 2, ≤ 2^(C_S_AXI_ADDR_WIDTH-2).
- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  reset; synchronous and active-low.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit k gates WDATA[8k+7:8k].
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- REG_OUT  out  NUM_REGS*32  register contents; register i is at bits [32i+31:32i].
- REG_WR_PULSE  out  NUM_REGS  one-cycle pulse on the commit of a write to register i.

## Operation
- Reset (ARESETN low at an edge):
  - All registers are cleared to 0.
  - Both holding latches are emptied.
  - Every output goes to 0: all READY/VALID signals, BRESP, RRESP, RDATA, REG_OUT, REG_WR_PULSE.
  - An `rst_done` flop is cleared.
- `rst_done` sets on the first edge with ARESETN high. All READYs stay low until it is set.
- Write address/data capture:
  - AW and W are captured independently into one-entry latches, aw_held and w_held.
  - S_AXI_AWREADY = rst_done & !aw_held & !S_AXI_BVALID.
  - S_AXI_WREADY = rst_done & !w_held & !S_AXI_BVALID.
  - Either channel may arrive first, or both may arrive in the same cycle.
- Write commit: on an edge where aw_held & w_held & !S_AXI_BVALID:
  - Apply the strobed bytes to the indexed register.
  - Pulse REG_WR_PULSE[idx] for one cycle.
  - Set BVALID, load BRESP, clear both latches.
- Write response: BVALID holds, with BRESP stable, until the edge where BREADY=1. No new AW/W is accepted while BVALID is high.
- Read: S_AXI_ARREADY = rst_done & !S_AXI_RVALID. On the AR handshake edge:
  - RDATA is loaded with the register value as it was before that edge.
  - RRESP is loaded, and RVALID is set.
  - RVALID, RDATA and RRESP hold until RREADY=1.
- Simultaneous read and write commit to the same register: the read returns the old value. The write still commits.
- RDATA returns to 0 when RVALID drops.
- Responses: OKAY = 2'b00; SLVERR = 2'b10, only when the Configuration feature is enabled.
- Reset asserted mid-transaction: all pending latches and responses are discarded, with no partial write.

## Timing
- AW and W handshake at edge N → register, REG_OUT and REG_WR_PULSE update at edge N+1, with BVALID high after N+1. Minimum of 2 cycles from AW to B.
- AR handshake at edge N → RVALID high after edge N. Read latency is 1 cycle.
- Back-to-back reads with RREADY held high: one read every 2 cycles, because ARREADY is low while RVALID is high.
- Back-to-back writes with BREADY held high: one write every 3 cycles.
- REG_OUT is registered and reflects the committed value from the commit edge onward.

## Configuration
- AXI_REG_FILE_SLVERR_EN defined:
  - An index ≥ NUM_REGS is out of range.
  - An out-of-range write changes no register, pulses nothing, and returns BRESP=SLVERR.
  - An out-of-range read returns RDATA=0 with RRESP=SLVERR.
- Undefined: the index is reduced modulo NUM_REGS (upper index bits are ignored), so out-of-range addresses alias onto implemented registers. Responses are always OKAY.

## Test plan
- Reset for 20 cycles, then write 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC. Read all four back → 1, 2, 3, 4, with every BRESP/RRESP = OKAY and REG_OUT = {4, 3, 2, 1}.
- W presented 3 cycles before AW → WREADY drops after the W capture. The commit and BVALID come 1 cycle after the AW handshake, and REG_WR_PULSE[idx] is high for exactly 1 cycle.
- Register holds 0x11111111; write 0xAABBCCDD with WSTRB=4'b0010 → readback 0x1111CC11.
- BREADY held low for 5 cycles after a write → BVALID and BRESP stay stable, AWREADY/WREADY stay low, and a queued second write commits only after B completes.
- Write 0xDEADBEEF to 0x10 with NUM_REGS=4:
  - with AXI_REG_FILE_SLVERR_EN, BRESP=SLVERR, register 0 is unchanged, and a read of 0x10 returns 0 with SLVERR;
  - without it, register 0 becomes 0xDEADBEEF with OKAY.
- AR to 0x4 on the same edge that a write of 0x55 to 0x4 commits → RDATA is the old value, and the next read returns 0x55. Then assert ARESETN low with BVALID pending → all outputs are 0 on the next edge and REG_OUT = 0.
